// File: rtl/pid_loop_ctrl.sv
// PID loop controller for the GPSDO OCXO tuning path: phase error in, clamped PWM duty out.
// One shared multiplier is sequenced IDLE -> ERR -> MP -> MI -> MD -> OUT.
module pid_loop_ctrl #(
  parameter int                 PHASE_W  = 24,
  parameter int                 ERR_W    = 16,
  parameter int                 OUT_W    = 17,
  parameter int                 ACC_W    = 40,
  parameter logic signed [15:0] KP       = 16'sd500,
  parameter logic signed [15:0] KI       = 16'sd50,
  parameter logic signed [15:0] KD       = 16'sd0,
  parameter int                 TARGET   = 1,
  parameter int                 DUTY_MID = 32768,
  parameter int                 DUTY_MIN = 0,
  parameter int                 DUTY_MAX = 65535,
  parameter int                 INT_LIM  = 32767,
  parameter int                 LOCK_TH  = 8,
  parameter int                 LOCK_CNT = 16
) (
  input  logic                      CLK_SYS,
  input  logic                      CLK_RST,
  input  logic signed [PHASE_W-1:0] Measure_Phase,
  input  logic                      Measure_Done,
  input  logic                      Hold,
  output logic [OUT_W-1:0]          PWM_Duty,
  output logic                      Duty_Valid,
  output logic                      Led_Lock,
  output logic [7:0]                Data,
  output logic                      Uart_En,
  output logic                      Busy,
  output logic                      Overrun,
  output logic [2:0]                dbg_state
);

  // Measurement handshake: Measure_Done is a one-cycle valid with no ready;
  // a strobe that lands while Busy is dropped and latched into Overrun.

  typedef enum logic [2:0] {S_IDLE, S_ERR, S_MP, S_MI, S_MD, S_OUT} state_t;

  localparam int CW = $clog2(LOCK_CNT + 1);
  localparam int PW = 16 + ERR_W + 1;

  localparam logic signed [PHASE_W:0] TGT_W    = (PHASE_W + 1)'(TARGET);
  localparam logic signed [PHASE_W:0] ERR_MAX  = (PHASE_W + 1)'((2 ** (ERR_W - 1)) - 1);
  localparam logic signed [PHASE_W:0] ERR_MIN  = -(PHASE_W + 1)'(2 ** (ERR_W - 1));
  localparam logic signed [ERR_W:0]   ILIM_P   = (ERR_W + 1)'(INT_LIM);
  localparam logic signed [ERR_W:0]   ILIM_N   = -(ERR_W + 1)'(INT_LIM);
  localparam logic signed [ACC_W:0]   MID_W    = (ACC_W + 1)'(DUTY_MID);
  localparam logic signed [ACC_W:0]   MAX_W    = (ACC_W + 1)'(DUTY_MAX);
  localparam logic signed [ACC_W:0]   MIN_W    = (ACC_W + 1)'(DUTY_MIN);
  localparam logic [OUT_W-1:0]        DMAX_O   = OUT_W'(DUTY_MAX);
  localparam logic [OUT_W-1:0]        DMIN_O   = OUT_W'(DUTY_MIN);
  localparam logic [OUT_W-1:0]        DMID_O   = OUT_W'(DUTY_MID);
  localparam logic [ERR_W:0]          LTH_W    = (ERR_W + 1)'(LOCK_TH);
  localparam logic [CW-1:0]           LCNT_W   = CW'(LOCK_CNT);

  state_t state, state_nx;

  logic signed [PHASE_W-1:0] phase_q;
  logic signed [ERR_W-1:0]   en_q, en_1, integ, int_nx_q;
  logic signed [ACC_W-1:0]   acc;
  logic [CW-1:0]             lock_cnt;

  logic signed [PHASE_W:0]   diff_wide;
  logic signed [ERR_W-1:0]   en_sat;
  logic signed [ERR_W:0]     int_sum;
  logic signed [ERR_W-1:0]   int_sat;
  logic signed [ERR_W:0]     d_diff;
  logic signed [15:0]        mul_a;
  logic signed [ERR_W:0]     mul_b;
  logic signed [PW-1:0]      product;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W:0]     sum;
  logic [OUT_W-1:0]          duty_nx;
  logic                      sat_hi, sat_lo, windup;
  logic [ERR_W:0]            en_abs;
  logic [CW-1:0]             lock_nx;

  assign Busy      = (state != S_IDLE);
  assign dbg_state = state;

  always_ff @(posedge CLK_SYS or posedge CLK_RST) begin
    if (CLK_RST) state <= S_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (Measure_Done && !Hold) state_nx = S_ERR;
      S_ERR:   state_nx = S_MP;
      S_MP:    state_nx = S_MI;
      S_MI:    state_nx = S_MD;
      S_MD:    state_nx = S_OUT;
      S_OUT:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Error and integrator candidate, both saturated before they are registered.
  always_comb begin
    diff_wide = $signed({phase_q[PHASE_W-1], phase_q}) - TGT_W;
    if (diff_wide > ERR_MAX)      en_sat = ERR_MAX[ERR_W-1:0];
    else if (diff_wide < ERR_MIN) en_sat = ERR_MIN[ERR_W-1:0];
    else                          en_sat = diff_wide[ERR_W-1:0];

    int_sum = $signed({integ[ERR_W-1], integ}) + $signed({en_sat[ERR_W-1], en_sat});
    if (int_sum > ILIM_P)      int_sat = ILIM_P[ERR_W-1:0];
    else if (int_sum < ILIM_N) int_sat = ILIM_N[ERR_W-1:0];
    else                       int_sat = int_sum[ERR_W-1:0];

    d_diff = $signed({en_q[ERR_W-1], en_q}) - $signed({en_1[ERR_W-1], en_1});
  end

  // Shared multiplier operand select.
  always_comb begin
    mul_a = KP;
    mul_b = {en_q[ERR_W-1], en_q};
    case (state)
      S_MI: begin
        mul_a = KI;
        mul_b = {int_nx_q[ERR_W-1], int_nx_q};
      end
      S_MD: begin
        mul_a = KD;
        mul_b = d_diff;
      end
      default: ;
    endcase
    product  = mul_a * mul_b;
    prod_ext = {{(ACC_W - PW){product[PW-1]}}, product};
  end

  always_comb begin
    sum    = MID_W + $signed({acc[ACC_W-1], acc});
    sat_hi = (sum > MAX_W);
    sat_lo = (sum < MIN_W);
    if (sat_hi)      duty_nx = DMAX_O;
    else if (sat_lo) duty_nx = DMIN_O;
    else             duty_nx = sum[OUT_W-1:0];
    windup = (sat_hi && !en_q[ERR_W-1] && (en_q != '0)) || (sat_lo && en_q[ERR_W-1]);

    en_abs = en_q[ERR_W-1] ? -{en_q[ERR_W-1], en_q} : {en_q[ERR_W-1], en_q};
    if (en_abs > LTH_W)         lock_nx = '0;
    else if (lock_cnt == LCNT_W) lock_nx = lock_cnt;
    else                         lock_nx = lock_cnt + 1'b1;
  end

  always_ff @(posedge CLK_SYS or posedge CLK_RST) begin
    if (CLK_RST) begin
      phase_q    <= '0;
      en_q       <= '0;
      en_1       <= '0;
      integ      <= '0;
      int_nx_q   <= '0;
      acc        <= '0;
      lock_cnt   <= '0;
      PWM_Duty   <= DMID_O;
      Duty_Valid <= 1'b0;
      Uart_En    <= 1'b0;
      Led_Lock   <= 1'b0;
      Data       <= '0;
      Overrun    <= 1'b0;
    end else begin
      Duty_Valid <= 1'b0;
      Uart_En    <= 1'b0;
      if (Measure_Done && state != S_IDLE) Overrun <= 1'b1;
      case (state)
        S_IDLE: begin
          if (Measure_Done) begin
            if (Hold) begin
              lock_cnt <= '0;
              Led_Lock <= 1'b0;
            end else begin
              phase_q <= Measure_Phase;
            end
          end
        end
        S_ERR: begin
          en_q     <= en_sat;
          int_nx_q <= int_sat;
        end
        S_MP:        acc <= prod_ext;
        S_MI, S_MD:  acc <= acc + prod_ext;
        S_OUT: begin
          PWM_Duty   <= duty_nx;
          if (!windup) integ <= int_nx_q;
          en_1       <= en_q;
          Data       <= en_q[7:0];
          Duty_Valid <= 1'b1;
          Uart_En    <= 1'b1;
          lock_cnt   <= lock_nx;
          Led_Lock   <= (lock_nx == LCNT_W);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/pid_loop_ctrl.md
Name: pid_loop_ctrl

Overview:
- Parametrised, clock-synchronous PID loop controller for the GPSDO OCXO tuning path.
- Consumes each signed phase-error measurement from the phase meter and computes a clamped PWM duty word. The computation uses one time-shared multiplier driven by a small state machine.
- Adds integrator limiting, anti-windup, optional derivative term, lock detection with hysteresis count, hold mode, overrun flag and a UART telemetry strobe.

Parameters:
- PHASE_W, 24, width of Measure_Phase (signed two's complement)
- ERR_W, 16, width of internal error and integrator (signed)
- OUT_W, 17, width of PWM_Duty
- ACC_W, 40, width of PID accumulator (signed)
- KP, 500, proportional gain (signed 16-bit)
- KI, 50, integral gain (signed 16-bit)
- KD, 0, derivative gain (signed 16-bit)
- TARGET, 1, phase setpoint subtracted from Measure_Phase
- DUTY_MID, 32768, duty offset added to the PID sum
- DUTY_MIN, 0, lower duty clamp
- DUTY_MAX, 65535, upper duty clamp
- INT_LIM, 32767, integrator magnitude limit (symmetric, ≤ 2^(ERR_W-1)-1)
- LOCK_TH, 8, maximum |error| counted as in-lock
- LOCK_CNT, 16, consecutive in-lock samples required to assert Led_Lock

Ports:
- CLK_SYS  in  1  system clock; all logic on rising edge
- CLK_RST  in  1  asynchronous, active-high reset
- Measure_Phase  in  PHASE_W  signed phase difference; negative = local leads, positive = GPS leads
- Measure_Done  in  1  one-cycle strobe, CLK_SYS-synchronous; Measure_Phase valid in that cycle
- Hold  in  1  level; when 1, incoming samples are discarded (duty frozen)
- PWM_Duty  out  OUT_W  registered duty word
- Duty_Valid  out  1  one-cycle pulse when PWM_Duty updates
- Led_Lock  out  1  lock indicator
- Data  out  8  telemetry byte: error[7:0]
- Uart_En  out  1  one-cycle pulse, coincident with Duty_Valid
- Busy  out  1  high while FSM is not IDLE
- Overrun  out  1  sticky; set when Measure_Done arrives while Busy; cleared only by reset

Behaviour:
- Reset (async, CLK_RST=1): PWM_Duty=DUTY_MID; Duty_Valid, Uart_En, Led_Lock, Busy, Overrun all 0; Data=0; integrator, en_1 and lock counter are 0; FSM in IDLE.
- FSM: IDLE → ERR → MP → MI → MD → OUT → IDLE. There is exactly one multiplier; each Mx state performs one multiply-accumulate.
- IDLE:
  - Measure_Done=1 and Hold=0: capture Measure_Phase, go to ERR.
  - Measure_Done=1 and Hold=1: discard the sample, clear the lock counter and Led_Lock, stay in IDLE, no Duty_Valid.
- ERR:
  - en = Measure_Phase − TARGET, computed at PHASE_W+1 bits, then saturated to the signed ERR_W range.
  - int_nx = integrator + en, clamped to [−INT_LIM, +INT_LIM].
- MP: acc = KP·en. MI: acc += KI·int_nx. MD: acc += KD·(en − en_1), with the difference computed at ERR_W+1 bits. All arithmetic is signed and sign-extended to ACC_W.
- OUT:
  - sum = DUTY_MID + acc, then clamp to [DUTY_MIN, DUTY_MAX] and register into PWM_Duty.
  - Anti-windup: commit integrator ← int_nx unless (sum > DUTY_MAX and en > 0) or (sum < DUTY_MIN and en < 0). In either of those cases the integrator is unchanged.
  - en_1 ← en. Data ← en[7:0].
  - Duty_Valid=1 and Uart_En=1 for this one cycle.
  - Lock: if |en| ≤ LOCK_TH, increment the lock counter, saturating at LOCK_CNT. Otherwise clear the counter. Led_Lock=1 iff counter==LOCK_CNT.
- Latency: Measure_Done sampled at edge E → PWM_Duty/Duty_Valid change at edge E+5, visible in the cycle after. Minimum sample spacing is 6 cycles.
- Measure_Done while Busy: sample ignored, Overrun set, current computation unaffected.
- Hold rising during a computation: the computation completes normally; Hold is only examined in IDLE.
- Reset mid-computation: the FSM aborts immediately and all state returns to reset values; no Duty_Valid is generated.

Test Plan:
- Reset, no strobes → PWM_Duty=32768, Led_Lock=0, Busy=0, Overrun=0.
- Measure_Phase=11, strobe → en=10, PWM_Duty=32768+5000+500=38268 at latency 6, Duty_Valid and Uart_En single pulse, Data=0x0A; then strobe Measure_Phase=1 → en=0, PWM_Duty=32768+0+500=33268.
- Measure_Phase=257 → sum 173568 clamps PWM_Duty=65535, integrator stays 0; Measure_Phase=−9 → en=−10, PWM_Duty=27268, integrator=−10.
- 16 strobes with Measure_Phase=5 (en=4) → Led_Lock rises exactly on the 16th Duty_Valid; one strobe with Measure_Phase=20 → Led_Lock=0 at the next Duty_Valid.
- Second Measure_Done 2 cycles after first → Overrun=1, only one Duty_Valid, result equals the first sample alone; Hold=1 strobe → no Duty_Valid, PWM_Duty unchanged, Led_Lock cleared.
- Assert CLK_RST during MI → outputs return to reset values asynchronously, no Duty_Valid; a following sample computes as from a fresh reset.
